// File: rtl/mux_fifo_n.sv
// rtl/mux_fifo_n.sv - N-channel select mux feeding an in-order output FIFO
// with a valid/ready output handshake and a saturating overflow-drop counter.
module mux_fifo_n #(
  parameter int D_WIDTH    = 8,
  parameter int NUM_CH     = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SEL_WIDTH-1:0]            select,
  input  logic [NUM_CH*D_WIDTH-1:0]       data_i,
  input  logic [NUM_CH-1:0]               valid_i,
  input  logic                            flush_i,
  output logic [D_WIDTH-1:0]              data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            full_o,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  output logic [CNT_WIDTH-1:0]            drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [D_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [CNT_WIDTH-1:0] drop_cnt;

  logic                 sel_valid;
  logic [D_WIDTH-1:0]   sel_data;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;

  // An out-of-range select matches no channel, so it never requests a push.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (select == SEL_WIDTH'(k)) begin
        sel_valid = valid_i[k];
        sel_data  = data_i[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = !empty && ready_i;
  assign push_ok = sel_valid && (!full || pop);
  assign drop    = sel_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem[wr_ptr] <= sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Drops are only counted outside a flush cycle, where the push is discarded anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && !flush_i && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign data_o     = empty ? '0 : mem[rd_ptr];
  assign valid_o    = !empty;
  assign full_o     = full;
  assign level_o    = level;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_mux_fifo_n.sv
// tb/tb_mux_fifo_n.sv - directed self-checking bench for mux_fifo_n
// (3 channels of 8 bits, depth-4 FIFO, 16-bit drop counter).
module tb_mux_fifo_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  select;
  logic [23:0] data_i;
  logic [2:0]  valid_i;
  logic        flush_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        full_o;
  logic [2:0]  level_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  mux_fifo_n dut (
    .clk        (clk),
    .rst        (rst),
    .select     (select),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .full_o     (full_o),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [7:0] val);
    data_i[k*8 +: 8] = val;
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [7:0] d,
                               input logic f, input logic [2:0] lvl, input logic [15:0] dc);
    check({tag, ".valid"}, 32'(valid_o), 32'(v));
    check({tag, ".data"},  32'(data_o), 32'(d));
    check({tag, ".full"},  32'(full_o), 32'(f));
    check({tag, ".level"}, 32'(level_o), 32'(lvl));
    check({tag, ".drop"},  32'(drop_cnt_o), 32'(dc));
  endtask

  initial begin
    logic [7:0] exp_q [4];

    rst     = 1'b1;
    select  = 2'd0;
    data_i  = '0;
    valid_i = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    #12;
    check_outputs("reset", 1'b0, 8'h00, 1'b0, 3'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single word through an empty FIFO: one-cycle latency, then popped.
    select  = 2'd1;
    valid_i = 3'b010;
    set_ch(1, 8'hA5);
    ready_i = 1'b1;
    step();
    check_outputs("single", 1'b1, 8'hA5, 1'b0, 3'd1, 16'd0);
    valid_i = 3'b000;
    step();
    check_outputs("single_pop", 1'b0, 8'h00, 1'b0, 3'd0, 16'd0);

    // Only an unselected channel is valid: nothing is pushed.
    select  = 2'd0;
    valid_i = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step();
      check("unsel.valid", 32'(valid_o), 32'd0);
      check("unsel.level", 32'(level_o), 32'd0);
    end

    // Stalled downstream, six pushes into depth four: two drops.
    ready_i = 1'b0;
    select  = 2'd2;
    valid_i = 3'b100;
    for (int i = 1; i <= 6; i++) begin
      set_ch(2, 8'(i));
      step();
    end
    check_outputs("overflow", 1'b1, 8'h01, 1'b1, 3'd4, 16'd2);
    valid_i = 3'b000;
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain.data", 32'(data_o), 32'(i));
      check("drain.valid", 32'(valid_o), 32'd1);
      step();
    end
    check_outputs("drained", 1'b0, 8'h00, 1'b0, 3'd0, 16'd2);

    // Refill to full, then push and pop on the same edge.
    ready_i = 1'b0;
    valid_i = 3'b100;
    for (int i = 0; i < 4; i++) begin
      set_ch(2, 8'h11 + 8'(i));
      step();
    end
    check_outputs("refill", 1'b1, 8'h11, 1'b1, 3'd4, 16'd2);
    ready_i = 1'b1;
    set_ch(2, 8'h7E);
    step();
    check_outputs("full_push_pop", 1'b1, 8'h12, 1'b1, 3'd4, 16'd2);
    valid_i = 3'b000;
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h7E};
    for (int i = 0; i < 4; i++) begin
      check("order.data", 32'(data_o), 32'(exp_q[i]));
      step();
    end
    check_outputs("order_end", 1'b0, 8'h00, 1'b0, 3'd0, 16'd2);

    // Out-of-range select with every channel valid: no push, no drop.
    ready_i = 1'b0;
    select  = 2'd3;
    valid_i = 3'b111;
    step();
    step();
    check_outputs("sel_oob", 1'b0, 8'h00, 1'b0, 3'd0, 16'd2);

    // Flush with three words buffered; the same-cycle push and pop are discarded.
    select  = 2'd0;
    valid_i = 3'b001;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 8'h21 + 8'(i));
      step();
    end
    check_outputs("pre_flush", 1'b1, 8'h21, 1'b0, 3'd3, 16'd2);
    set_ch(0, 8'h99);
    ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 3'b000;
    check_outputs("flush", 1'b0, 8'h00, 1'b0, 3'd0, 16'd2);

    // Asynchronous reset between clock edges clears everything immediately.
    ready_i = 1'b0;
    valid_i = 3'b001;
    set_ch(0, 8'h31);
    step();
    set_ch(0, 8'h32);
    step();
    valid_i = 3'b000;
    check_outputs("pre_rst", 1'b1, 8'h31, 1'b0, 3'd2, 16'd2);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 8'h00, 1'b0, 3'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_outputs("post_rst", 1'b0, 8'h00, 1'b0, 3'd0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
